// File: rtl/module_name_core_pkg.sv
// Shared constants for the input conditioner: default sizing and reset values.
`timescale 1ns/1ps
package module_name_core_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int COUNT_W_DEFAULT         = 8;

  localparam logic                       SYNC_RESET     = 1'b0;
  localparam logic                       D_STABLE_RESET = 1'b0;
  localparam logic [COUNT_W_DEFAULT-1:0] Q_RESET        = '0;

  // Debounce counter must hold DEBOUNCE_CYCLES-1; one spare bit keeps cycles=1 legal.
  function automatic int debounce_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/module_name_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, cleared by reset.
`timescale 1ns/1ps
module module_name_sync2
  import module_name_core_pkg::*;
(
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic sync1;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1 <= SYNC_RESET;
      q     <= SYNC_RESET;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/module_name_core.sv
// Input conditioner: synchronise D, debounce it, emit edge pulses and count rising edges.
`timescale 1ns/1ps
module module_name_core
  import module_name_core_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int COUNT_W         = COUNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               D,
  output logic               d_sync,
  output logic               d_stable,
  output logic               d_rise,
  output logic               d_fall,
  output logic [COUNT_W-1:0] q
);

  localparam int               CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  logic             accept;

  module_name_sync2 u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (D),
    .q    (d_sync)
  );

  // The mismatch has persisted for DEBOUNCE_CYCLES consecutive samples.
  assign accept = (d_sync != d_stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      d_stable <= D_STABLE_RESET;
      d_rise   <= 1'b0;
      d_fall   <= 1'b0;
    end else begin
      d_rise <= 1'b0;
      d_fall <= 1'b0;
      if (d_sync == d_stable) begin
        cnt <= '0;
      end else if (accept) begin
        cnt      <= '0;
        d_stable <= d_sync;
        d_rise   <= d_sync;
        d_fall   <= ~d_sync;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q <= COUNT_W'(Q_RESET);
    end else if (accept && d_sync) begin
      q <= q + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_module_name_core.sv
// Scoreboard bench for module_name_core: stimulus queues expected edge events, a monitor checks them.
`timescale 1ns/1ps
module tb_module_name_core;

  localparam int LAT = 6;  // drive at negedge after edge N -> update on edge N+6

  logic       tb_clk;
  logic       nrst;
  logic       D;
  logic       d_sync;
  logic       d_stable;
  logic       d_rise;
  logic       d_fall;
  logic [7:0] q;

  typedef struct {
    logic       rise;
    logic [7:0] q;
    int         cyc;
  } ev_t;

  ev_t        sb[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_err = 0;
  logic [7:0] model_q = 8'h00;

  module_name_core dut (
    .clk      (tb_clk),
    .nrst     (nrst),
    .D        (D),
    .d_sync   (d_sync),
    .d_stable (d_stable),
    .d_rise   (d_rise),
    .d_fall   (d_fall),
    .q        (q)
  );

  initial begin
    tb_clk = 1'b0;
    forever #50 tb_clk = ~tb_clk;
  end

  always @(posedge tb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every edge pulse must match the oldest queued expectation.
  always @(negedge tb_clk) begin
    if (nrst === 1'b1 && (d_rise === 1'b1 || d_fall === 1'b1)) begin
      n_checks++;
      if (d_rise === 1'b1 && d_fall === 1'b1) begin
        n_err++;
        $display("FAIL edge_excl: d_rise and d_fall both high at cycle %0d", cyc);
      end else if (sb.size() == 0) begin
        n_err++;
        $display("FAIL edge_unexpected: rise=%0b q=%0h at cycle %0d, none expected",
                 d_rise, q, cyc);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.rise !== d_rise || e.q !== q || e.cyc != cyc) begin
          n_err++;
          $display("FAIL edge_event: got rise=%0b q=%0h cyc=%0d expected rise=%0b q=%0h cyc=%0d",
                   d_rise, q, cyc, e.rise, e.q, e.cyc);
        end
      end
    end
  end

  task automatic press();
    @(negedge tb_clk);
    D = 1'b1;
    model_q = model_q + 8'h01;
    sb.push_back('{rise: 1'b1, q: model_q, cyc: cyc + LAT});
    repeat (10) @(negedge tb_clk);
  endtask

  task automatic release_d();
    @(negedge tb_clk);
    D = 1'b0;
    sb.push_back('{rise: 1'b0, q: model_q, cyc: cyc + LAT});
    repeat (10) @(negedge tb_clk);
  endtask

  task automatic do_reset();
    @(negedge tb_clk);
    nrst = 1'b0;
    D = 1'b0;
    model_q = 8'h00;
    @(negedge tb_clk);
    nrst = 1'b1;
  endtask

  initial begin
    int n0;
    // Power-on reset, with a clock edge and D=1 inside reset
    nrst = 1'b0;
    D = 1'b0;
    #25;
    check("por_q", 32'(q), 32'h00);
    check("por_stable", 32'(d_stable), 32'h0);
    D = 1'b1;
    @(posedge tb_clk);
    #1;
    check("por_hold", {28'h0, d_sync, d_stable, d_rise, d_fall}, 32'h0);
    check("por_hold_q", 32'(q), 32'h00);
    D = 1'b0;
    @(negedge tb_clk);
    nrst = 1'b1;
    #1.1;
    check("por_release_q", 32'(q), 32'h00);
    check("por_release_stable", 32'(d_stable), 32'h0);

    // Clean press: rise with q=01 on the 6th posedge
    @(negedge tb_clk);
    D = 1'b1;
    n0 = cyc;
    model_q = 8'h01;
    sb.push_back('{rise: 1'b1, q: 8'h01, cyc: n0 + 6});
    repeat (5) @(negedge tb_clk);
    check("press_not_early", 32'(d_stable), 32'h0);
    @(negedge tb_clk);
    check("press_q", 32'(q), 32'h01);
    check("press_stable", 32'(d_stable), 32'h1);
    @(negedge tb_clk);
    check("press_rise_one_cycle", 32'(d_rise), 32'h0);
    check("press_q_hold", 32'(q), 32'h01);
    repeat (4) @(negedge tb_clk);

    // Release: fall pulse, q unchanged
    release_d();
    check("release_stable", 32'(d_stable), 32'h0);
    check("release_q", 32'(q), 32'h01);

    // Glitch reject (3 cycles) then accept (4 cycles)
    do_reset();
    @(negedge tb_clk);
    D = 1'b1;
    repeat (3) @(negedge tb_clk);
    D = 1'b0;
    repeat (10) @(negedge tb_clk);
    check("glitch_stable", 32'(d_stable), 32'h0);
    check("glitch_q", 32'(q), 32'h00);
    @(negedge tb_clk);
    D = 1'b1;
    n0 = cyc;
    model_q = 8'h01;
    sb.push_back('{rise: 1'b1, q: 8'h01, cyc: n0 + 6});
    repeat (4) @(negedge tb_clk);
    D = 1'b0;
    sb.push_back('{rise: 1'b0, q: 8'h01, cyc: n0 + 10});
    repeat (10) @(negedge tb_clk);
    check("accept4_q", 32'(q), 32'h01);

    // Wrap: 255 pairs -> FF, 256th -> 00
    do_reset();
    for (int i = 0; i < 255; i++) begin
      press();
      release_d();
    end
    check("wrap_255", 32'(q), 32'hFF);
    press();
    release_d();
    check("wrap_256", 32'(q), 32'h00);

    // Reset mid-debounce with q=05
    do_reset();
    for (int i = 0; i < 5; i++) begin
      press();
      release_d();
    end
    check("mid_q5", 32'(q), 32'h05);
    @(negedge tb_clk);
    D = 1'b1;
    repeat (4) @(negedge tb_clk);
    #1;
    nrst = 1'b0;
    #1;
    check("mid_reset_outs", {28'h0, d_sync, d_stable, d_rise, d_fall}, 32'h0);
    check("mid_reset_q", 32'(q), 32'h00);
    model_q = 8'h00;
    @(negedge tb_clk);
    nrst = 1'b1;
    n0 = cyc;
    model_q = 8'h01;
    sb.push_back('{rise: 1'b1, q: 8'h01, cyc: n0 + 6});
    repeat (5) @(negedge tb_clk);
    check("mid_restart_not_early", 32'(d_stable), 32'h0);
    repeat (5) @(negedge tb_clk);
    check("mid_restart_q", 32'(q), 32'h01);
    release_d();

    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
